segment_counter_display: RTL and testbench

Parametrised successor to the single-mode board counter display. It adds the following:
- up/down counting with a programmable modulus and wrap-around;
- synchronous parallel load;
- step edge detection;
- a sequential (shift-and-add-3) binary-to-BCD converter with change tracking;
- optional leading-zero blanking;
- selectable segment polarity.

It sits between the board KEY/SW inputs (already synchronised, active-high) and the HEX digit pins.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/bcd_serial_converter.sv | 102 ++++++++++
 rtl/segment_counter_display.sv | 127 ++++++++++++
 tb/tb_segment_counter_display.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and glyph tables for the segment counter display.
// Holds the converter state enum, 0-9 glyphs and the glyph decode helper.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Active-high glyphs, bit order g..a
  localparam logic [6:0] GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] bcd_to_glyph(
    input logic [3:0] nibble
  );
    if (nibble <= 4'd9) begin
      return GLYPH[nibble];
    end
    return SEG_OFF;
  endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// Sequential shift-and-add-3 binary to BCD converter.
// Ports: clock, reset, start/bin_in in; busy, done, bcd_out out.
module bcd_serial_converter
  import seg_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  conv_state_t      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bcd_d   = scr_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/segment_counter_display.sv
// Up/down modulo counter with load, feeding a serial BCD converter and HEX decode.
// Ports: clock, reset, step, up, load, load_value, blank_zeros in; count, wrap, busy, segments out.
module segment_counter_display
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int WIDTH      = 14,
  parameter int MODULUS    = 10000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   up,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   blank_zeros,
  output logic [WIDTH-1:0]       count,
  output logic                   wrap,
  output logic                   busy,
  output logic [DIGITS-1:0][6:0] segments
);

  if (MODULUS > (1 << WIDTH)) begin : g_bad_width
    $error("WIDTH too small for MODULUS");
  end
  if (MODULUS > 10 ** DIGITS) begin : g_bad_digits
    $error("DIGITS too few for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic             step_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             pending_q, pending_d;
  logic             step_ev;
  logic             changed;
  logic             start;
  logic             conv_busy;
  logic             conv_done_unused;
  logic [4*DIGITS-1:0] bcd;

  assign step_ev = step & ~step_q;
  assign start   = pending_q & ~conv_busy;

  always_comb begin
    count_d   = count_q;
    wrap_d    = 1'b0;
    changed   = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_CNT) ? MAX_CNT : load_value;
      changed = 1'b1;
    end else if (step_ev) begin
      changed = 1'b1;
      if (up) begin
        if (count_q == MAX_CNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    // A change landing on the start cycle must survive the clear
    pending_d = pending_q;
    if (start) pending_d = 1'b0;
    if (changed) pending_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q    <= 1'b0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      step_q    <= step;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      pending_q <= pending_d;
    end
  end

  bcd_serial_converter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (count_q),
    .busy    (conv_busy),
    .done    (conv_done_unused),
    .bcd_out (bcd)
  );

  logic [3:0] nib;
  logic [6:0] pat;
  logic       lead;

  // lead stays set while every digit above (and this one) is zero
  always_comb begin
    nib  = '0;
    pat  = SEG_OFF;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      pat = bcd_to_glyph(nib);
      if (nib != 4'd0) lead = 1'b0;
      if (blank_zeros && (i > 0) && lead) pat = SEG_OFF;
      segments[i] = ACTIVE_LOW ? ~pat : pat;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign busy  = conv_busy;

endmodule

// File: tb/tb_segment_counter_display.sv
// Randomized and directed bench for segment_counter_display.
// Compares every cycle against a decimal reference model of count and display.
module tb_segment_counter_display;

  localparam int DIGITS  = 4;
  localparam int WIDTH   = 14;
  localparam int MODULUS = 10000;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   step;
  logic                   up;
  logic                   load;
  logic [WIDTH-1:0]       load_value;
  logic                   blank_zeros;
  logic [WIDTH-1:0]       count;
  logic                   wrap;
  logic                   busy;
  logic [DIGITS-1:0][6:0] segments;

  segment_counter_display #(
    .DIGITS     (DIGITS),
    .WIDTH      (WIDTH),
    .MODULUS    (MODULUS),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .up          (up),
    .load        (load),
    .load_value  (load_value),
    .blank_zeros (blank_zeros),
    .count       (count),
    .wrap        (wrap),
    .busy        (busy),
    .segments    (segments)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int m_cnt, m_wrap, m_pend, m_left, m_fly, m_disp;
  bit m_prev;

  logic [6:0] ref_glyph [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_segs(input int v, input bit bz);
    logic [31:0] r;
    int nd;
    int x;
    r  = '0;
    nd = 1;
    x  = v / 10;
    while (x > 0) begin
      nd++;
      x = x / 10;
    end
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      logic [6:0] g;
      g = ref_glyph[x % 10];
      if (bz && i >= nd) g = 7'b0000000;
      r[7*i +: 7] = ~g;
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_edge();
    bit ev;
    bit chg;
    if (reset) begin
      m_cnt = 0; m_wrap = 0; m_pend = 0;
      m_left = 0; m_disp = 0; m_prev = 0;
      return;
    end
    ev     = step && !m_prev;
    m_prev = step;
    m_wrap = 0;
    chg    = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_disp = m_fly;
    end else if (m_pend != 0) begin
      m_fly  = m_cnt;
      m_pend = 0;
      m_left = WIDTH + 1;
    end
    if (load) begin
      m_cnt = (int'(load_value) >= MODULUS) ? MODULUS - 1 : int'(load_value);
      chg   = 1;
    end else if (ev) begin
      chg = 1;
      if (up) begin
        if (m_cnt == MODULUS - 1) begin m_cnt = 0; m_wrap = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = MODULUS - 1; m_wrap = 1; end
        else m_cnt = m_cnt - 1;
      end
    end
    if (chg) m_pend = 1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("count", 32'(count), 32'(m_cnt));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("segs", 32'(segments), exp_segs(m_disp, blank_zeros));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit dir);
    up = dir; step = 1'b1; tick();
    step = 1'b0; tick();
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = WIDTH'(v); tick();
    load = 1'b0;
  endtask

  initial begin
    int bc;
    int wc;
    bit saw1234;
    bit saw1235;
    reset = 1'b1; step = 1'b0; up = 1'b1; load = 1'b0;
    load_value = '0; blank_zeros = 1'b0;
    idle(2);
    check("rst_segs", 32'(segments), {4'h0, {4{7'b1000000}}});
    reset = 1'b0;
    idle(2);

    repeat (4) begin pulse(1'b1); idle(18); end
    check("cnt4", 32'(count), 32'd4);
    check("seg0004", 32'(segments),
          {4'h0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0011001});

    up = 1'b1; step = 1'b1; tick(); step = 1'b0;
    bc = 0;
    repeat (30) begin tick(); if (busy) bc++; end
    check("busy_len", bc, WIDTH + 1);

    do_load(9998); idle(20);
    pulse(1'b1); idle(20);
    wc = 0;
    up = 1'b1; step = 1'b1; tick(); if (wrap) wc++;
    step = 1'b0;
    repeat (20) begin tick(); if (wrap) wc++; end
    check("wrap_once", wc, 1);
    check("seg0000", 32'(segments), {4'h0, {4{7'b1000000}}});
    blank_zeros = 1'b1; tick();
    check("seg___0", 32'(segments), {4'h0, {3{7'b1111111}}, 7'b1000000});
    blank_zeros = 1'b0;

    up = 1'b0; step = 1'b1; tick(); step = 1'b0;
    check("dn_cnt", 32'(count), 32'd9999);
    check("dn_wrap", 32'(wrap), 32'd1);
    idle(17);
    check("seg9999", 32'(segments), {4'h0, {4{7'b0010000}}});
    do_load(12345);
    check("clamp", 32'(count), 32'd9999);
    check("clamp_wrap", 32'(wrap), 32'd0);

    up = 1'b1; step = 1'b1; idle(50); step = 1'b0; tick();
    check("hold_one", 32'(count), 32'd0);
    load = 1'b1; load_value = WIDTH'(100); step = 1'b1; tick();
    load = 1'b0; step = 1'b0; tick();
    check("load_wins", 32'(count), 32'd100);
    idle(20);

    do_load(1234);
    repeat (3) pulse(1'b1);
    saw1234 = 0; saw1235 = 0;
    repeat (60) begin
      tick();
      if (32'(segments) == exp_segs(1234, 0)) saw1234 = 1;
      if (32'(segments) == exp_segs(1235, 0)) saw1235 = 1;
    end
    check("saw1234", 32'(saw1234), 32'd1);
    check("no1235", 32'(saw1235), 32'd0);
    check("seg1237", 32'(segments), exp_segs(1237, 0));
    check("idle_busy", 32'(busy), 32'd0);

    idle(5);
    do_load(5678); idle(5);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    idle(40);
    check("no_stale", 32'(segments), {4'h0, {4{7'b1000000}}});

    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) step = ~step;
      up = 1'($urandom);
      load = ($urandom_range(0, 79) == 0);
      load_value = WIDTH'($urandom_range(0, 16383));
      if ($urandom_range(0, 99) == 0) blank_zeros = ~blank_zeros;
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; load = 1'b0; step = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
